// File: rtl/mem_access.sv
// Memory-access stage: issues one data-memory transaction per load/store and forwards WB control.
// Optional access watchdog enabled by defining MEM_ACCESS_TIMEOUT_EN.
module mem_access (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [1:0]  ex_size,
  input  logic        ex_unsigned,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic [4:0]  ex_rd,
  input  logic [4:0]  ex_rt,
  input  logic        ex_mux2,
  input  logic        ex_mux3,
  input  logic        ex_wr,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall,
  output logic [31:0] dato_mem,
  output logic [31:0] ALU,
  output logic [4:0]  rd,
  output logic [4:0]  rt,
  output logic        Mux_flag_2_M,
  output logic        Mux_flag_3_M,
  output logic        banco_flag_wr_M,
  output logic        MEM_WB_enable,
  output logic        misalign
`ifdef MEM_ACCESS_TIMEOUT_EN
  ,
  output logic        timeout
`endif
);

`ifdef MEM_ACCESS_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE, ACCESS, TIMEOUT} state_t;
  logic [4:0] cnt_q;
`else
  typedef enum logic [1:0] {IDLE, ACCESS} state_t;
`endif

  state_t state_q, state_d;

  logic [31:0] op_addr;
  logic [4:0]  op_rd, op_rt;
  logic        op_m2, op_m3, op_wr, op_load, op_uns;
  logic [1:0]  op_size;

  logic        is_mem, is_misal;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  assign is_mem   = ex_mem_read | ex_mem_write;
  assign is_misal = ((ex_size == 2'b01) && ex_addr[0]) || (ex_size[1] && (ex_addr[1:0] != 2'b00));

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = ex_wdata;
    case (ex_size)
      2'b00: begin
        st_be    = 4'b0001 << ex_addr[1:0];
        st_wdata = {4{ex_wdata[7:0]}};
      end
      2'b01: begin
        st_be    = ex_addr[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{ex_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Little-endian lane select on the latched address of the outstanding load
  always_comb begin
    ld_byte = dmem_rdata[7:0];
    case (op_addr[1:0])
      2'b01:   ld_byte = dmem_rdata[15:8];
      2'b10:   ld_byte = dmem_rdata[23:16];
      2'b11:   ld_byte = dmem_rdata[31:24];
      default: ;
    endcase
    ld_half = op_addr[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (op_size)
      2'b00:   ld_data = {{24{~op_uns & ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = {{16{~op_uns & ld_half[15]}}, ld_half};
      default: ld_data = dmem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ex_valid && is_mem && !is_misal) state_d = ACCESS;
      ACCESS: begin
        if (dmem_ack) state_d = IDLE;
`ifdef MEM_ACCESS_TIMEOUT_EN
        else if (cnt_q == 5'd0) state_d = TIMEOUT;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dmem_req <= 1'b0; dmem_we <= 1'b0; dmem_be <= 4'b0;
      dmem_addr <= 32'b0; dmem_wdata <= 32'b0;
      stall <= 1'b0; misalign <= 1'b0; MEM_WB_enable <= 1'b1;
      dato_mem <= 32'b0; ALU <= 32'b0; rd <= 5'b0; rt <= 5'b0;
      Mux_flag_2_M <= 1'b0; Mux_flag_3_M <= 1'b0; banco_flag_wr_M <= 1'b0;
      op_addr <= 32'b0; op_rd <= 5'b0; op_rt <= 5'b0; op_size <= 2'b0;
      op_m2 <= 1'b0; op_m3 <= 1'b0; op_wr <= 1'b0; op_load <= 1'b0; op_uns <= 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
      cnt_q <= 5'd0; timeout <= 1'b0;
`endif
    end else begin
      MEM_WB_enable <= 1'b1;
      misalign      <= 1'b0;
      stall         <= (state_d != IDLE);
`ifdef MEM_ACCESS_TIMEOUT_EN
      timeout <= 1'b0;
`endif
      case (state_q)
        IDLE: if (ex_valid) begin
          if (is_mem && !is_misal) begin
            op_addr <= ex_addr; op_rd <= ex_rd; op_rt <= ex_rt; op_size <= ex_size;
            op_m2 <= ex_mux2; op_m3 <= ex_mux3; op_wr <= ex_wr;
            op_load <= ex_mem_read; op_uns <= ex_unsigned;
            dmem_req   <= 1'b1;
            dmem_we    <= ~ex_mem_read;
            dmem_addr  <= {ex_addr[31:2], 2'b00};
            dmem_be    <= st_be;
            dmem_wdata <= st_wdata;
`ifdef MEM_ACCESS_TIMEOUT_EN
            cnt_q <= 5'd15;
`endif
          end else begin
            ALU <= ex_addr; rd <= ex_rd; rt <= ex_rt;
            Mux_flag_2_M <= ex_mux2; Mux_flag_3_M <= ex_mux3;
            banco_flag_wr_M <= ex_wr & ~(is_mem & is_misal);
            misalign        <= is_mem & is_misal;
            MEM_WB_enable   <= 1'b0;
          end
        end
        ACCESS: begin
          if (dmem_ack) begin
            ALU <= op_addr; rd <= op_rd; rt <= op_rt;
            Mux_flag_2_M <= op_m2; Mux_flag_3_M <= op_m3; banco_flag_wr_M <= op_wr;
            if (op_load) dato_mem <= ld_data;
            dmem_req <= 1'b0; dmem_we <= 1'b0; dmem_be <= 4'b0;
            MEM_WB_enable <= 1'b0;
          end
`ifdef MEM_ACCESS_TIMEOUT_EN
          else if (cnt_q == 5'd0) begin
            dmem_req <= 1'b0; dmem_we <= 1'b0; dmem_be <= 4'b0;
            timeout  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 5'd1;
          end
`endif
        end
        default: begin
          ALU <= op_addr; rd <= op_rd; rt <= op_rt;
          Mux_flag_2_M <= op_m2; Mux_flag_3_M <= op_m3; banco_flag_wr_M <= 1'b0;
          dato_mem <= 32'b0;
          MEM_WB_enable <= 1'b0;
        end
      endcase
    end
  end

endmodule
